// File: rtl/game_pkg.sv
// Constants shared by the digger, bullet, gob and move_arbiter blocks:
// object type codes, request codes, status field layout and arbiter state encoding.
package game_pkg;

    localparam int NREQ              = 4;
    localparam int H_WIDTH           = 4;
    localparam int V_WIDTH           = 4;
    localparam int TYPE_WIDTH        = 4;
    localparam int STATUS_WIDTH      = 16;
    localparam int REQ_TYPE_WIDTH    = 2;
    localparam int REQ_CONTENT_WIDTH = 8;
    localparam int ADDR_WIDTH        = 8;
    localparam int HMAX              = 15;
    localparam int VMAX              = 10;
    localparam int IDX_W             = $clog2(NREQ);

    localparam logic [TYPE_WIDTH-1:0] OBJ_EMPTY  = 4'd0;
    localparam logic [TYPE_WIDTH-1:0] OBJ_DIGGER = 4'd1;
    localparam logic [TYPE_WIDTH-1:0] OBJ_BULLET = 4'd5;
    localparam logic [TYPE_WIDTH-1:0] OBJ_GOB0   = 4'd6;
    localparam logic [TYPE_WIDTH-1:0] OBJ_GOB1   = 4'd7;
    localparam logic [TYPE_WIDTH-1:0] OBJ_GOB2   = 4'd8;
    localparam logic [TYPE_WIDTH-1:0] OBJ_BLOCK  = 4'd15;

    localparam logic [REQ_TYPE_WIDTH-1:0] REQ_MOVE      = 2'b00;
    localparam logic [REQ_TYPE_WIDTH-1:0] REQ_SHOOT     = 2'b01;
    localparam logic [REQ_TYPE_WIDTH-1:0] REQ_DISAPPEAR = 2'b10;
    localparam logic [REQ_TYPE_WIDTH-1:0] REQ_RSVD      = 2'b11;

    // status = {exist[15:14], x[13:10], y[9:6], dir[5:4], type[3:0]}
    localparam int ST_EXIST_LSB = 14;
    localparam int ST_EXIST_W   = 2;
    localparam int ST_X_LSB     = 10;
    localparam int ST_Y_LSB     = 6;
    localparam int ST_DIR_LSB   = 4;
    localparam int ST_TYPE_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_DECIDE = 3'd2,
        S_COMMIT = 3'd3,
        S_CLEAR  = 3'd4
    } arb_state_t;

    function automatic logic [ADDR_WIDTH-1:0] cell_addr(input logic [H_WIDTH-1:0] x,
                                                        input logic [V_WIDTH-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/move_arbiter_if.sv
// Requester and level-map bus of the move arbiter. The arbiter is the slave of the
// requesters; the master side drives requests and returns map read data.
interface move_arbiter_if;
    import game_pkg::*;

    // req is a level held by each requester until it sees its one-cycle ack or nack;
    // req_type/req_content/status must be stable while req is high.
    logic [NREQ-1:0]                   req;
    logic [NREQ*REQ_TYPE_WIDTH-1:0]    req_type;
    logic [NREQ*REQ_CONTENT_WIDTH-1:0] req_content;
    logic [NREQ*STATUS_WIDTH-1:0]      status;
    logic [NREQ-1:0]                   ack;
    logic [NREQ-1:0]                   nack;
    logic [NREQ-1:0]                   wr;
    logic [STATUS_WIDTH-1:0]           data_out;
    logic [ADDR_WIDTH-1:0]             map_addr;
    logic [TYPE_WIDTH-1:0]             map_rd_data;
    logic                              map_we;
    logic [TYPE_WIDTH-1:0]             map_wr_data;
    logic                              hit_valid;
    logic [REQ_CONTENT_WIDTH-1:0]      hit_cell;

    modport master (
        output req, req_type, req_content, status, map_rd_data,
        input  ack, nack, wr, data_out, map_addr, map_we, map_wr_data, hit_valid, hit_cell
    );

    modport slave (
        input  req, req_type, req_content, status, map_rd_data,
        output ack, nack, wr, data_out, map_addr, map_we, map_wr_data, hit_valid, hit_cell
    );

endinterface

// File: rtl/move_arbiter_rr_picker.sv
// Round-robin priority encoder: picks the first set request at or after rr_ptr, wrapping.
module rr_picker
    import game_pkg::*;
(
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [IDX_W-1:0] cand;

    // Scan farthest offset first so the nearest set bit is the last one written.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % NREQ);
            if (req[cand]) begin
                grant_idx   = cand;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/move_arbiter.sv
// Serialises move/shoot/disappear requests against the shared level map, answers each
// with a one-cycle ack or nack, commits accepted changes and resolves bullet-hits-gob.
module move_arbiter
    import game_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    move_arbiter_if.slave bus,
    output arb_state_t    dbg_state
);

    arb_state_t                    state_q, state_d;
    logic [IDX_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [REQ_TYPE_WIDTH-1:0]     rtype_q, rtype_d;
    logic [H_WIDTH-1:0]            tgt_x_q, tgt_x_d, src_x_q, src_x_d;
    logic [V_WIDTH-1:0]            tgt_y_q, tgt_y_d, src_y_q, src_y_d;
    logic [TYPE_WIDTH-1:0]         src_type_q, src_type_d;
    logic                          bad_q, bad_d;
    logic                          clr_pend_q, clr_pend_d;
    logic [ADDR_WIDTH-1:0]         wr_addr_q, wr_addr_d;
    logic [NREQ-1:0]               ack_q, ack_d, nack_q, nack_d, wr_q, wr_d;
    logic [STATUS_WIDTH-1:0]       data_out_q, data_out_d;
    logic                          map_we_q, map_we_d;
    logic [TYPE_WIDTH-1:0]         map_wr_data_q, map_wr_data_d;
    logic                          hit_valid_q, hit_valid_d;
    logic [REQ_CONTENT_WIDTH-1:0]  hit_cell_q, hit_cell_d;

    logic [IDX_W-1:0]              grant_idx;
    logic                          grant_valid;
    logic [REQ_TYPE_WIDTH-1:0]     sel_type;
    logic [REQ_CONTENT_WIDTH-1:0]  sel_content;
    logic [STATUS_WIDTH-1:0]       sel_status;
    logic                          hit_found;
    logic [IDX_W-1:0]              hit_idx;
    logic [STATUS_WIDTH-1:0]       hit_status;
    logic [TYPE_WIDTH-1:0]         cell_t;

    rr_picker u_picker (
        .req         (bus.req),
        .rr_ptr      (rr_ptr_q),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        sel_type    = '0;
        sel_content = '0;
        sel_status  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                sel_type    = bus.req_type[i*REQ_TYPE_WIDTH +: REQ_TYPE_WIDTH];
                sel_content = bus.req_content[i*REQ_CONTENT_WIDTH +: REQ_CONTENT_WIDTH];
                sel_status  = bus.status[i*STATUS_WIDTH +: STATUS_WIDTH];
            end
        end
    end

    // Lowest-index live object standing on the target cell is the one a bullet kills.
    always_comb begin
        logic [STATUS_WIDTH-1:0] st_i;
        hit_found  = 1'b0;
        hit_idx    = '0;
        hit_status = '0;
        st_i       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            st_i = bus.status[i*STATUS_WIDTH +: STATUS_WIDTH];
            if ((st_i[ST_EXIST_LSB +: ST_EXIST_W] != '0) &&
                (st_i[ST_X_LSB +: H_WIDTH] == tgt_x_q) &&
                (st_i[ST_Y_LSB +: V_WIDTH] == tgt_y_q)) begin
                hit_found  = 1'b1;
                hit_idx    = IDX_W'(i);
                hit_status = st_i;
            end
        end
    end

    assign cell_t = bus.map_rd_data;

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        idx_d         = idx_q;
        rtype_d       = rtype_q;
        tgt_x_d       = tgt_x_q;
        tgt_y_d       = tgt_y_q;
        src_x_d       = src_x_q;
        src_y_d       = src_y_q;
        src_type_d    = src_type_q;
        bad_d         = bad_q;
        clr_pend_d    = clr_pend_q;
        wr_addr_d     = wr_addr_q;
        ack_d         = '0;
        nack_d        = '0;
        wr_d          = '0;
        data_out_d    = data_out_q;
        map_we_d      = 1'b0;
        map_wr_data_d = '0;
        hit_valid_d   = 1'b0;
        hit_cell_d    = hit_cell_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    idx_d      = grant_idx;
                    rr_ptr_d   = IDX_W'((int'(grant_idx) + 1) % NREQ);
                    rtype_d    = sel_type;
                    tgt_x_d    = sel_content[V_WIDTH +: H_WIDTH];
                    tgt_y_d    = sel_content[0 +: V_WIDTH];
                    src_x_d    = sel_status[ST_X_LSB +: H_WIDTH];
                    src_y_d    = sel_status[ST_Y_LSB +: V_WIDTH];
                    src_type_d = sel_status[ST_TYPE_LSB +: TYPE_WIDTH];
                    bad_d      = ({1'b0, sel_content[V_WIDTH +: H_WIDTH]} > (H_WIDTH+1)'(HMAX)) ||
                                 ({1'b0, sel_content[0 +: V_WIDTH]} > (V_WIDTH+1)'(VMAX)) ||
                                 (sel_type == REQ_RSVD);
                    state_d    = S_READ;
                end
            end
            S_READ: state_d = S_DECIDE;
            S_DECIDE: begin
                state_d    = S_COMMIT;
                clr_pend_d = 1'b0;
                wr_addr_d  = cell_addr(tgt_x_q, tgt_y_q);
                if (bad_q) begin
                    nack_d[idx_q] = 1'b1;
                end else begin
                    unique case (rtype_q)
                        REQ_MOVE: begin
                            if (cell_t == OBJ_EMPTY) begin
                                ack_d[idx_q]  = 1'b1;
                                map_we_d      = 1'b1;
                                map_wr_data_d = src_type_q;
                                clr_pend_d    = 1'b1;
                            end else if ((src_type_q == OBJ_BULLET) &&
                                         (cell_t >= OBJ_GOB0) && (cell_t <= OBJ_GOB2)) begin
                                nack_d[idx_q] = 1'b1;
                                map_we_d      = 1'b1;
                                map_wr_data_d = OBJ_EMPTY;
                                hit_valid_d   = 1'b1;
                                hit_cell_d    = {tgt_x_q, tgt_y_q};
                                clr_pend_d    = 1'b1;
                                if (hit_found) begin
                                    wr_d[hit_idx] = 1'b1;
                                    data_out_d    = {2'b00, hit_status[STATUS_WIDTH-3:0]};
                                end
                            end else begin
                                nack_d[idx_q] = 1'b1;
                                // A blocked bullet is spent either way.
                                clr_pend_d    = (src_type_q == OBJ_BULLET);
                            end
                        end
                        REQ_SHOOT: begin
                            if (cell_t == OBJ_EMPTY) begin
                                ack_d[idx_q]  = 1'b1;
                                map_we_d      = 1'b1;
                                map_wr_data_d = OBJ_BULLET;
                            end else begin
                                nack_d[idx_q] = 1'b1;
                            end
                        end
                        REQ_DISAPPEAR: begin
                            ack_d[idx_q]  = 1'b1;
                            map_we_d      = 1'b1;
                            map_wr_data_d = OBJ_EMPTY;
                            wr_addr_d     = cell_addr(src_x_q, src_y_q);
                        end
                        default: nack_d[idx_q] = 1'b1;
                    endcase
                end
            end
            S_COMMIT: begin
                if (clr_pend_q) begin
                    state_d       = S_CLEAR;
                    map_we_d      = 1'b1;
                    map_wr_data_d = OBJ_EMPTY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rr_ptr_q      <= '0;
            idx_q         <= '0;
            rtype_q       <= '0;
            tgt_x_q       <= '0;
            tgt_y_q       <= '0;
            src_x_q       <= '0;
            src_y_q       <= '0;
            src_type_q    <= '0;
            bad_q         <= 1'b0;
            clr_pend_q    <= 1'b0;
            wr_addr_q     <= '0;
            ack_q         <= '0;
            nack_q        <= '0;
            wr_q          <= '0;
            data_out_q    <= '0;
            map_we_q      <= 1'b0;
            map_wr_data_q <= '0;
            hit_valid_q   <= 1'b0;
            hit_cell_q    <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            idx_q         <= idx_d;
            rtype_q       <= rtype_d;
            tgt_x_q       <= tgt_x_d;
            tgt_y_q       <= tgt_y_d;
            src_x_q       <= src_x_d;
            src_y_q       <= src_y_d;
            src_type_q    <= src_type_d;
            bad_q         <= bad_d;
            clr_pend_q    <= clr_pend_d;
            wr_addr_q     <= wr_addr_d;
            ack_q         <= ack_d;
            nack_q        <= nack_d;
            wr_q          <= wr_d;
            data_out_q    <= data_out_d;
            map_we_q      <= map_we_d;
            map_wr_data_q <= map_wr_data_d;
            hit_valid_q   <= hit_valid_d;
            hit_cell_q    <= hit_cell_d;
        end
    end

    // Invalid targets never reach the map, so the read address stays parked at 0.
    always_comb begin
        bus.map_addr = '0;
        unique case (state_q)
            S_READ, S_DECIDE: bus.map_addr = bad_q ? '0 : cell_addr(tgt_x_q, tgt_y_q);
            S_COMMIT:         bus.map_addr = wr_addr_q;
            S_CLEAR:          bus.map_addr = cell_addr(src_x_q, src_y_q);
            default:          bus.map_addr = '0;
        endcase
    end

    assign bus.ack         = ack_q;
    assign bus.nack        = nack_q;
    assign bus.wr          = wr_q;
    assign bus.data_out    = data_out_q;
    assign bus.map_we      = map_we_q;
    assign bus.map_wr_data = map_wr_data_q;
    assign bus.hit_valid   = hit_valid_q;
    assign bus.hit_cell    = hit_cell_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_move_arbiter.sv
// Bench for move_arbiter: directed scenarios plus randomized request rounds checked
// against a transaction-level model of the arbitration and map rules.
module tb_move_arbiter;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  move_arbiter_if bus();
  arb_state_t dbg_state;

  move_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // Level map RAM: registered read, written by the DUT or bulk-loaded by the bench.
  logic [3:0] ram [256];
  logic [3:0] init_map [256];
  logic       load_map;
  always @(posedge clk) begin
    if (load_map) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_map[i];
    end else if (bus.map_we) begin
      ram[bus.map_addr] <= bus.map_wr_data;
    end
    bus.map_rd_data <= ram[bus.map_addr];
  end

  int tests_run = 0;
  int tests_failed = 0;
  int cyc;
  int ptr_m;

  logic [15:0]     st [NREQ];
  logic [1:0]      rt [NREQ];
  logic [7:0]      rc [NREQ];
  logic [NREQ-1:0] rq;
  logic [3:0]      ref_map [256];

  logic [2*NREQ-1:0] exp_resp_q[$];
  int                exp_time_q[$];
  logic [11:0]       exp_we_q[$];
  logic [NREQ+15:0]  exp_wr_q[$];
  logic [7:0]        exp_hit_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [3:0] data);
    ref_map[addr] = data;
    exp_we_q.push_back({addr, data});
  endtask

  // Walks the pending set in round-robin order and predicts every observable effect.
  task automatic plan_round();
    logic [NREQ-1:0] pend;
    int t;
    pend = rq;
    t = 3;
    while (pend != 0) begin
      int g;
      logic [3:0] x, y, sx, sy, otype, tcell;
      logic [7:0] tgt, src;
      logic ok, clr, found;
      logic [NREQ-1:0] onehot, vic;
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && pend[(ptr_m + k) % NREQ]) g = (ptr_m + k) % NREQ;
      x = rc[g][7:4]; y = rc[g][3:0];
      sx = st[g][13:10]; sy = st[g][9:6]; otype = st[g][3:0];
      tgt = {y, x}; src = {sy, sx};
      ok = 1'b0; clr = 1'b0; found = 1'b0;
      if (y > 4'(VMAX) || rt[g] == REQ_RSVD) begin
        ok = 1'b0;
      end else if (rt[g] == REQ_DISAPPEAR) begin
        ok = 1'b1;
        model_write(src, OBJ_EMPTY);
      end else begin
        tcell = ref_map[tgt];
        if (rt[g] == REQ_SHOOT) begin
          if (tcell == OBJ_EMPTY) begin ok = 1'b1; model_write(tgt, OBJ_BULLET); end
        end else if (tcell == OBJ_EMPTY) begin
          ok = 1'b1; model_write(tgt, otype); clr = 1'b1;
        end else if (otype == OBJ_BULLET && tcell >= OBJ_GOB0 && tcell <= OBJ_GOB2) begin
          model_write(tgt, OBJ_EMPTY);
          exp_hit_q.push_back(rc[g]);
          clr = 1'b1;
          for (int i = 0; i < NREQ; i++) begin
            if (!found && st[i][15:14] != 2'b00 && st[i][13:6] == {x, y}) begin
              found = 1'b1;
              vic = '0; vic[i] = 1'b1;
              exp_wr_q.push_back({vic, 2'b00, st[i][13:0]});
            end
          end
        end else begin
          clr = (otype == OBJ_BULLET);
        end
      end
      if (clr) model_write(src, OBJ_EMPTY);
      onehot = '0; onehot[g] = 1'b1;
      exp_resp_q.push_back(ok ? {onehot, {NREQ{1'b0}}} : {{NREQ{1'b0}}, onehot});
      exp_time_q.push_back(t);
      t += clr ? 5 : 4;
      ptr_m = (g + 1) % NREQ;
      pend[g] = 1'b0;
    end
  endtask

  // One negedge: compare every DUT event against the head of its expected queue.
  task automatic step();
    logic [2*NREQ-1:0] rsp;
    @(negedge clk);
    cyc++;
    rsp = {bus.ack, bus.nack};
    if (rsp != 0) begin
      if (exp_resp_q.size() == 0) check("resp_extra", 32'(rsp), 0);
      else begin
        check("resp", 32'(rsp), 32'(exp_resp_q.pop_front()));
        check("resp_cycle", cyc, exp_time_q.pop_front());
      end
      bus.req = bus.req & ~(bus.ack | bus.nack);
    end
    if (bus.map_we) begin
      if (exp_we_q.size() == 0) check("map_wr_extra", {1'b1, bus.map_addr, bus.map_wr_data}, 0);
      else check("map_wr", {bus.map_addr, bus.map_wr_data}, 32'(exp_we_q.pop_front()));
    end
    if (bus.wr != 0) begin
      if (exp_wr_q.size() == 0) check("status_wr_extra", {bus.wr, bus.data_out}, 0);
      else check("status_wr", {bus.wr, bus.data_out}, 32'(exp_wr_q.pop_front()));
    end
    if (bus.hit_valid) begin
      if (exp_hit_q.size() == 0) check("hit_extra", {1'b1, bus.hit_cell}, 0);
      else check("hit_cell", 32'(bus.hit_cell), 32'(exp_hit_q.pop_front()));
    end
  endtask

  task automatic drive_fields();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_type[i*2 +: 2]    = rt[i];
      bus.req_content[i*8 +: 8] = rc[i];
      bus.status[i*16 +: 16]    = st[i];
    end
  endtask

  task automatic run_round(input string name);
    int n, mism;
    for (int i = 0; i < 256; i++) ref_map[i] = init_map[i];
    plan_round();
    @(negedge clk); load_map = 1'b1;
    @(negedge clk); load_map = 1'b0;
    drive_fields();
    bus.req = rq;
    cyc = 0;
    n = 0;
    while (exp_resp_q.size() != 0 && n < 100) begin step(); n++; end
    check(name, exp_resp_q.size(), 0);
    repeat (3) step();
    check("effects_left", exp_we_q.size() + exp_wr_q.size() + exp_hit_q.size(), 0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_map[i]) mism++;
    check("map_final", mism, 0);
    bus.req = '0;
    exp_resp_q.delete(); exp_time_q.delete(); exp_we_q.delete();
    exp_wr_q.delete(); exp_hit_q.delete();
  endtask

  task automatic clear_stim();
    rq = '0;
    for (int i = 0; i < NREQ; i++) begin st[i] = '0; rt[i] = '0; rc[i] = '0; end
    for (int i = 0; i < 256; i++) init_map[i] = OBJ_EMPTY;
  endtask

  task automatic set_status(input int i, input logic [1:0] ex, input logic [3:0] x,
                            input logic [3:0] y, input logic [3:0] ty);
    st[i] = {ex, x, y, 2'b00, ty};
  endtask

  task automatic set_req(input int i, input logic [1:0] t, input logic [3:0] x, input logic [3:0] y);
    rt[i] = t; rc[i] = {x, y}; rq[i] = 1'b1;
  endtask

  logic [3:0] cell_tab [10];

  initial begin
    cell_tab = '{OBJ_EMPTY, OBJ_EMPTY, OBJ_EMPTY, OBJ_EMPTY, OBJ_DIGGER,
                 OBJ_BULLET, OBJ_GOB0, OBJ_GOB1, OBJ_GOB2, OBJ_BLOCK};
    rst_n = 1'b0;
    load_map = 1'b0;
    bus.req = '0; bus.req_type = '0; bus.req_content = '0; bus.status = '0;
    ptr_m = 0;
    clear_stim();
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, S_IDLE);
    check("rst_ack_nack_wr", {bus.ack, bus.nack, bus.wr}, 0);
    check("rst_map", {bus.map_we, bus.map_addr, bus.map_wr_data}, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_hit", {bus.hit_valid, bus.hit_cell}, 0);
    rst_n = 1'b1;

    // Digger moves into an empty cell.
    clear_stim();
    set_status(0, 2'b01, 4'd3, 4'd4, OBJ_DIGGER);
    set_req(0, REQ_MOVE, 4'd4, 4'd4);
    run_round("digger_move");

    // Bullet shoots into a block.
    clear_stim();
    set_status(1, 2'b01, 4'd4, 4'd4, OBJ_BULLET);
    set_req(1, REQ_SHOOT, 4'd5, 4'd4);
    init_map[8'h45] = OBJ_BLOCK;
    run_round("shoot_block");

    // Bullet flies into GOB1 owned by requester 2.
    clear_stim();
    set_status(1, 2'b01, 4'd5, 4'd4, OBJ_BULLET);
    set_status(2, 2'b01, 4'd6, 4'd4, OBJ_GOB1);
    set_req(1, REQ_MOVE, 4'd6, 4'd4);
    init_map[8'h45] = OBJ_BULLET;
    init_map[8'h46] = OBJ_GOB1;
    run_round("bullet_hit");

    // Out-of-range target.
    clear_stim();
    set_status(0, 2'b01, 4'd3, 4'd4, OBJ_DIGGER);
    set_req(0, REQ_MOVE, 4'd4, 4'd11);
    run_round("y_out_of_range");

    // Reset while the FSM sits in DECIDE.
    clear_stim();
    set_status(0, 2'b01, 4'd3, 4'd4, OBJ_DIGGER);
    rt[0] = REQ_MOVE; rc[0] = {4'd4, 4'd4};
    drive_fields();
    @(negedge clk); bus.req = 4'b0001;
    @(negedge clk); @(negedge clk);
    check("pre_rst_state", dbg_state, S_DECIDE);
    check("pre_rst_addr", bus.map_addr, 8'h44);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_state", dbg_state, S_IDLE);
    check("mid_rst_addr", bus.map_addr, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_quiet", {bus.ack, bus.nack, bus.wr, bus.map_we, bus.hit_valid}, 0);
    end
    bus.req = '0;
    rst_n = 1'b1;
    ptr_m = 0;

    // Two simultaneous requesters right after reset.
    clear_stim();
    set_status(0, 2'b01, 4'd3, 4'd4, OBJ_DIGGER);
    set_status(1, 2'b01, 4'd1, 4'd1, OBJ_BULLET);
    set_req(0, REQ_MOVE, 4'd4, 4'd4);
    set_req(1, REQ_SHOOT, 4'd2, 4'd1);
    run_round("pair_after_reset");

    for (int r = 0; r < 300; r++) begin
      clear_stim();
      for (int i = 0; i < NREQ; i++) begin
        logic [3:0] ty, tx, tyy;
        ty = (i == 0) ? OBJ_DIGGER : (i == 1) ? OBJ_BULLET : 4'(OBJ_GOB0 + (i - 2) % 3);
        st[i] = {2'($urandom_range(0, 3)), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
                 2'($urandom_range(0, 3)), ty};
        rt[i] = ($urandom_range(0, 9) < 6) ? REQ_MOVE : 2'($urandom_range(1, 3));
        tx = 4'($urandom_range(0, 4));
        tyy = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 4));
        rc[i] = {tx, tyy};
      end
      rq = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int yy = 0; yy < 5; yy++)
        for (int xx = 0; xx < 5; xx++)
          init_map[yy*16 + xx] = cell_tab[$urandom_range(0, 9)];
      run_round("random_round");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
